button_conditioner: RTL
=======================

# button_conditioner

Conditions the four raw active-low direction buttons before they reach the cursor-control logic in `main`. It synchronises each button, debounces it, and arbitrates between simultaneous presses. It emits single-cycle move events with a 2-bit direction code, and repeats them automatically while a button is held. The cursor logic steps the cursor once per `move_valid` pulse and no longer handles raw buttons.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required before a debounced level changes (20 ms at 50 MHz); legal range ≥ 1.
- `REPEAT_DELAY`, default 25_000_000: cycles from the first event to the first auto-repeat event; 0 disables auto-repeat.
- `REPEAT_PERIOD`, default 5_000_000: cycles between subsequent repeat events; legal range ≥ 1.
- `CNT_W`, default 25: width of the debounce and repeat counters; must hold every parameter value above.

Ports:
- `CLOCK_50`, input, 1: the only clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `up_but`, `down_but`, `left_but`, `right_but`, input, 1 each: raw buttons, asynchronous to the clock, low = pressed.
- `move_valid`, output, 1: one-cycle event pulse.
- `move_dir`, output, 2: direction code, meaningful while `move_valid` = 1. Codes: 00 up, 01 down, 10 left, 11 right.
- `pressed`, output, 4: debounced levels, active-high. Bit order: [3] up, [2] down, [1] left, [0] right.
- `holding`, output, 1: high while the FSM is in HOLD.

## Operation
- Synchroniser: two flops per button, reset value 1 (released).
- Debouncer, one per button:
  - A counter increments on each cycle where the synchronised level differs from the debounced level.
  - Any cycle where the two match clears the counter.
  - When the count reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
  - `pressed` is the inverse of the debounced level.
- FSM states:
  - IDLE: no event.
    - If any `pressed` bit is set, select the button by priority: up > down > left > right.
    - Latch its code into `move_dir` and pulse `move_valid`.
    - Load the repeat counter with `REPEAT_DELAY` and go to HOLD.
  - HOLD: other buttons are ignored.
    - If the latched button's `pressed` bit clears, go to RELEASE; no event is emitted.
    - Otherwise, when `REPEAT_DELAY` ≠ 0 and the repeat counter expires: pulse `move_valid` with the same `move_dir`, reload the counter with `REPEAT_PERIOD`, and stay in HOLD.
    - If release and expiry fall on the same cycle, release wins and no pulse is emitted.
  - RELEASE: wait until `pressed` = 0000, then go to IDLE. A second button held across the release does not generate an event until every button has been released and pressed again.
- `move_dir` holds its last latched value between events.
- Reset mid-operation: the FSM returns to IDLE, all counters clear, and any pending event is discarded.
- A button held through reset deassertion is treated as a new press once it has been debounced.

## Timing
- Reset values: `move_valid` = 0, `move_dir` = 00, `pressed` = 0000, `holding` = 0. The FSM is in IDLE and the synchroniser flops are 1.
- Press latency, with edge 0 defined as the first edge that samples the raw low level:
  - Synchroniser output goes low after edge 1.
  - `pressed` bit sets after edge 1 + `DEBOUNCE_CYCLES`.
  - `move_valid` is high for exactly the cycle after edge 2 + `DEBOUNCE_CYCLES`.
  - `holding` rises with the same edge as `move_valid`.
- Release latency: the `pressed` bit clears after edge 1 + `DEBOUNCE_CYCLES` from the first sampled high level. `holding` falls on the next edge.
- Repeat timing:
  - The first repeat pulse comes exactly `REPEAT_DELAY` cycles after the initial pulse.
  - Later repeat pulses are spaced exactly `REPEAT_PERIOD` cycles apart.
- `move_valid` is never high on two consecutive cycles unless `REPEAT_PERIOD` = 1.
- Glitches shorter than `DEBOUNCE_CYCLES` cycles never change `pressed` and never produce an event.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYCLES` = 4, `REPEAT_DELAY` = 20, `REPEAT_PERIOD` = 8.
- Clean press and release: hold `up_but` low for 10 cycles, then release.
  - Expect one `move_valid` pulse 6 cycles after the first sampling edge, with `move_dir` = 00.
  - `pressed` = 1000 during the hold.
  - No further pulses; `holding` returns to 0.
- Bounce rejection: toggle `left_but` low/high every 2 cycles for 20 cycles, then hold it low.
  - No event during the toggling.
  - Exactly one event with `move_dir` = 10, 6 cycles after the stable low begins.
- Auto-repeat: hold `right_but` for 60 cycles.
  - Pulses at offsets 0, 20, 28, 36, 44, 52 relative to the first pulse, all with `move_dir` = 11.
  - No pulse after the debounced release.
- Simultaneous press and priority: drive `down_but` and `right_but` low on the same cycle.
  - The event carries `move_dir` = 01.
  - Release `down_but` while `right_but` stays held: no event.
  - Release all, then press `right_but` again: event with `move_dir` = 11.
- Reset mid-hold: assert `reset` for 1 cycle, asynchronously between edges, during HOLD.
  - All outputs are 0 immediately.
  - The still-held button produces a fresh event 6 cycles after reset deassertion.
- Release/expiry collision: release the button so its debounced release lands on the cycle the repeat counter expires.
  - No pulse on that cycle; the FSM reaches IDLE once all buttons read released.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner
//   Synchronises, debounces and arbitrates the four active-low direction
//   buttons, and turns them into single-cycle move events with auto-repeat
//   for the cursor-control logic.
//
// Ports
//   CLOCK_50   in   clock, rising edge
//   reset      in   asynchronous, active-high reset
//   up_but     in   raw button, low = pressed (likewise down/left/right)
//   move_valid out  one-cycle move event
//   move_dir   out  [1:0] direction of the event: 00 up, 01 down, 10 left, 11 right
//   pressed    out  [3:0] debounced levels, active-high: [3] up [2] down [1] left [0] right
//   holding    out  high while a pressed button is being tracked for repeat
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD   = 5_000_000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       up_but,
  input  logic       down_but,
  input  logic       left_but,
  input  logic       right_but,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic [3:0] pressed,
  output logic       holding
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RP_LOAD = CNT_W'(REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RELEASE
  } state_t;

  state_t           state;
  logic [3:0]       raw;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       db_level;
  logic [CNT_W-1:0] db_cnt [4];
  logic [CNT_W-1:0] rep_cnt;
  logic             held;

  assign raw     = {up_but, down_but, left_but, right_but};
  assign pressed = ~db_level;

  // Direction code d belongs to pressed bit 3-d, which for two bits is ~d.
  assign held = pressed[~move_dir];

  function automatic logic [1:0] prio_dir(input logic [3:0] p);
    if (p[3])      return 2'b00;
    else if (p[2]) return 2'b01;
    else if (p[1]) return 2'b10;
    else           return 2'b11;
  endfunction

  // Synchroniser and per-button debouncer. The level flips on the
  // DEBOUNCE_CYCLES-th consecutive mismatching cycle.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1    <= '1;
      sync2    <= '1;
      db_level <= '1;
      for (int unsigned i = 0; i < 4; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_level[i] <= sync2[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + ONE;
        end
      end
    end
  end

  // Event FSM. Release is tested before expiry so it wins a same-cycle tie.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      move_valid <= 1'b0;
      move_dir   <= '0;
      holding    <= 1'b0;
      rep_cnt    <= '0;
    end else begin
      move_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|pressed) begin
            move_dir   <= prio_dir(pressed);
            move_valid <= 1'b1;
            holding    <= 1'b1;
            rep_cnt    <= RD_LOAD;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (!held) begin
            holding <= 1'b0;
            state   <= RELEASE;
          end else if (REPEAT_DELAY != 0) begin
            if (rep_cnt <= ONE) begin
              move_valid <= 1'b1;
              rep_cnt    <= RP_LOAD;
            end else begin
              rep_cnt <= rep_cnt - ONE;
            end
          end
        end
        RELEASE: begin
          if (pressed == 4'b0000) begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          holding <= 1'b0;
        end
      endcase
    end
  end

endmodule
